// File: rtl/blake2_pkg.sv
// Shared constants and types for the BLAKE2 compression engine:
// initial vectors, message schedule, G word selectors, rotation amounts.
package blake2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } st_e;

    localparam logic [31:0] IV32 [8] = '{
        32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
    };

    localparam logic [63:0] IV64 [8] = '{
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
        64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
        64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
    };

    localparam logic [3:0] SIGMA [10][16] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF},
        '{4'hE, 4'hA, 4'h4, 4'h8, 4'h9, 4'hF, 4'hD, 4'h6, 4'h1, 4'hC, 4'h0, 4'h2, 4'hB, 4'h7, 4'h5, 4'h3},
        '{4'hB, 4'h8, 4'hC, 4'h0, 4'h5, 4'h2, 4'hF, 4'hD, 4'hA, 4'hE, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
        '{4'h7, 4'h9, 4'h3, 4'h1, 4'hD, 4'hC, 4'hB, 4'hE, 4'h2, 4'h6, 4'h5, 4'hA, 4'h4, 4'h0, 4'hF, 4'h8},
        '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'hA, 4'hF, 4'hE, 4'h1, 4'hB, 4'hC, 4'h6, 4'h8, 4'h3, 4'hD},
        '{4'h2, 4'hC, 4'h6, 4'hA, 4'h0, 4'hB, 4'h8, 4'h3, 4'h4, 4'hD, 4'h7, 4'h5, 4'hF, 4'hE, 4'h1, 4'h9},
        '{4'hC, 4'h5, 4'h1, 4'hF, 4'hE, 4'hD, 4'h4, 4'hA, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hB},
        '{4'hD, 4'hB, 4'h7, 4'hE, 4'hC, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hF, 4'h4, 4'h8, 4'h6, 4'h2, 4'hA},
        '{4'h6, 4'hF, 4'hE, 4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'hC, 4'h2, 4'hD, 4'h7, 4'h1, 4'h4, 4'hA, 4'h5},
        '{4'hA, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hF, 4'hB, 4'h9, 4'hE, 4'h3, 4'hC, 4'hD, 4'h0}
    };

    // {a,b,c,d} word selectors: G0..G3 columns, G4..G7 diagonals
    localparam logic [15:0] GIDX [8] = '{
        16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
        16'h05AF, 16'h16BC, 16'h278D, 16'h349E
    };

    localparam int ROT32 [4] = '{32'd16, 32'd12, 32'd8,  32'd7};
    localparam int ROT64 [4] = '{32'd32, 32'd24, 32'd16, 32'd63};

endpackage

// File: rtl/blake2_g_core.sv
// Combinational BLAKE2 G mixing function on four state words and two
// message words; right-rotations by R0..R3.
module blake2_g_core #(
    parameter int W  = 32,
    parameter int R0 = 16,
    parameter int R1 = 12,
    parameter int R2 = 8,
    parameter int R3 = 7
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o
);

    function automatic logic [W-1:0] ror(input logic [W-1:0] val, input int n);
        return (val >> n) | (val << (W - n));
    endfunction

    logic [W-1:0] a1_s;
    logic [W-1:0] b1_s;
    logic [W-1:0] c1_s;
    logic [W-1:0] d1_s;

    // Two add/xor/rotate half-steps, first mixing in x then y
    always_comb begin
        a1_s = a_i + b_i + x_i;
        d1_s = ror(d_i ^ a1_s, R0);
        c1_s = c_i + d1_s;
        b1_s = ror(b_i ^ c1_s, R1);
        a_o  = a1_s + b1_s + y_i;
        d_o  = ror(d1_s ^ a_o, R2);
        c_o  = c1_s + d_o;
        b_o  = ror(b1_s ^ c_o, R3);
    end

endmodule

// File: rtl/blake2_compress_seq.sv
// Sequential BLAKE2 compression: loads the working vector from h, IV, the
// byte counter and the last flag, runs ROUNDS rounds of G through G_PAR
// shared cores, then folds the working vector into the new chaining value.
module blake2_compress_seq
    import blake2_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = 10,
    parameter int G_PAR  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*W-1:0]   in_h,
    input  logic [16*W-1:0]  in_m,
    input  logic [2*W-1:0]   in_t,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*W-1:0]   out_h,
    output logic             busy
);

    localparam int         NSTEP  = 8 / G_PAR;
    localparam logic [3:0] R_LAST = 4'(ROUNDS - 1);
    localparam logic [2:0] S_LAST = 3'(NSTEP - 1);
    localparam int ROT0 = (W == 64) ? ROT64[0] : ROT32[0];
    localparam int ROT1 = (W == 64) ? ROT64[1] : ROT32[1];
    localparam int ROT2 = (W == 64) ? ROT64[2] : ROT32[2];
    localparam int ROT3 = (W == 64) ? ROT64[3] : ROT32[3];

    if (W != 32 && W != 64) begin : g_bad_width
        $error("blake2_compress_seq: W must be 32 or 64");
    end
    if (G_PAR != 1 && G_PAR != 2 && G_PAR != 4) begin : g_bad_gpar
        $error("blake2_compress_seq: G_PAR must be 1, 2 or 4");
    end

    function automatic logic [W-1:0] iv_word(input int i);
        if (W == 64) return IV64[i][W-1:0];
        else         return W'(IV32[i]);
    endfunction

    st_e            st_q, st_d;
    logic [W-1:0]   v_q [16];
    logic [W-1:0]   v_d [16];
    logic [W-1:0]   m_q [16];
    logic [W-1:0]   m_d [16];
    logic [W-1:0]   h_q [8];
    logic [W-1:0]   h_d [8];
    logic [3:0]     r_q, r_d;
    logic [2:0]     s_q, s_d;
    logic           out_valid_q, out_valid_d;
    logic [8*W-1:0] out_h_q, out_h_d;

    logic [3:0]     row_s;
    logic [2:0]     gi_s [G_PAR];
    logic [3:0]     ia_s [G_PAR];
    logic [3:0]     ib_s [G_PAR];
    logic [3:0]     ic_s [G_PAR];
    logic [3:0]     id_s [G_PAR];
    logic [W-1:0]   ga_s [G_PAR];
    logic [W-1:0]   gb_s [G_PAR];
    logic [W-1:0]   gc_s [G_PAR];
    logic [W-1:0]   gd_s [G_PAR];
    logic [W-1:0]   gx_s [G_PAR];
    logic [W-1:0]   gy_s [G_PAR];
    logic [W-1:0]   oa_s [G_PAR];
    logic [W-1:0]   ob_s [G_PAR];
    logic [W-1:0]   oc_s [G_PAR];
    logic [W-1:0]   od_s [G_PAR];

    // Select state and message words for the G calls of the current step
    always_comb begin
        row_s = (r_q >= 4'd10) ? (r_q - 4'd10) : r_q;
        for (int k = 0; k < G_PAR; k++) begin
            gi_s[k] = s_q * 3'(G_PAR) + 3'(k);
            ia_s[k] = GIDX[gi_s[k]][15:12];
            ib_s[k] = GIDX[gi_s[k]][11:8];
            ic_s[k] = GIDX[gi_s[k]][7:4];
            id_s[k] = GIDX[gi_s[k]][3:0];
            ga_s[k] = v_q[ia_s[k]];
            gb_s[k] = v_q[ib_s[k]];
            gc_s[k] = v_q[ic_s[k]];
            gd_s[k] = v_q[id_s[k]];
            gx_s[k] = m_q[SIGMA[row_s][{gi_s[k], 1'b0}]];
            gy_s[k] = m_q[SIGMA[row_s][{gi_s[k], 1'b1}]];
        end
    end

    for (genvar k = 0; k < G_PAR; k++) begin : g_core
        blake2_g_core #(
            .W (W), .R0(ROT0), .R1(ROT1), .R2(ROT2), .R3(ROT3)
        ) u_g (
            .a_i(ga_s[k]), .b_i(gb_s[k]), .c_i(gc_s[k]), .d_i(gd_s[k]),
            .x_i(gx_s[k]), .y_i(gy_s[k]),
            .a_o(oa_s[k]), .b_o(ob_s[k]), .c_o(oc_s[k]), .d_o(od_s[k])
        );
    end

    // Next-state logic: accept only in IDLE, leave DONE on consumer handshake
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE: begin
                if (in_valid) st_d = RUN;
                else          st_d = IDLE;
            end
            RUN: begin
                if (s_q == S_LAST && r_q == R_LAST) st_d = FINAL;
                else                                st_d = RUN;
            end
            FINAL: st_d = DONE;
            DONE: begin
                if (out_ready) st_d = IDLE;
                else           st_d = DONE;
            end
            default: st_d = IDLE;
        endcase
    end

    // Datapath updates: load, G writeback, counter stepping, final fold
    always_comb begin
        v_d         = v_q;
        m_d         = m_q;
        h_d         = h_q;
        r_d         = r_q;
        s_d         = s_q;
        out_h_d     = out_h_q;
        out_valid_d = out_valid_q;
        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        h_d[i]     = in_h[W*i +: W];
                        v_d[i]     = in_h[W*i +: W];
                        v_d[i + 8] = iv_word(i);
                    end
                    for (int i = 0; i < 16; i++) begin
                        m_d[i] = in_m[W*i +: W];
                    end
                    v_d[12] = iv_word(4) ^ in_t[W-1:0];
                    v_d[13] = iv_word(5) ^ in_t[2*W-1:W];
                    v_d[14] = in_last ? ~iv_word(6) : iv_word(6);
                    r_d     = 4'd0;
                    s_d     = 3'd0;
                end else begin
                    v_d = v_q;
                end
            end
            RUN: begin
                for (int k = 0; k < G_PAR; k++) begin
                    v_d[ia_s[k]] = oa_s[k];
                    v_d[ib_s[k]] = ob_s[k];
                    v_d[ic_s[k]] = oc_s[k];
                    v_d[id_s[k]] = od_s[k];
                end
                if (s_q == S_LAST) begin
                    s_d = 3'd0;
                    r_d = r_q + 4'd1;
                end else begin
                    s_d = s_q + 3'd1;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    out_h_d[W*i +: W] = h_q[i] ^ v_q[i] ^ v_q[i + 8];
                end
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
                else           out_valid_d = 1'b1;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= IDLE;
        else        st_q <= st_d;
    end

    // Datapath and result registers; reset aborts any computation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                v_q[i] <= '0;
                m_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
            end
            r_q         <= 4'd0;
            s_q         <= 3'd0;
            out_valid_q <= 1'b0;
            out_h_q     <= '0;
        end else begin
            v_q         <= v_d;
            m_q         <= m_d;
            h_q         <= h_d;
            r_q         <= r_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_h_q     <= out_h_d;
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = (st_q == IDLE);
        busy      = (st_q != IDLE);
        out_valid = out_valid_q;
        out_h     = out_h_q;
    end

endmodule

// File: tb/tb_blake2_compress_seq.sv
// Directed bench for blake2_compress_seq: three BLAKE2s instances
// (G_PAR 4/2/1) share stimulus, one BLAKE2b instance has its own.
module tb_blake2_compress_seq;

    localparam logic [255:0] H32 =
        256'h5BE0CD19_1F83D9AB_9B05688C_510E527F_A54FF53A_3C6EF372_BB67AE85_6B08E647;
    localparam logic [511:0] H64 =
        512'h5BE0CD19137E2179_1F83D9ABFB41BD6B_9B05688C2B3E6C1F_510E527FADE682D1_A54FF53A5F1D36F1_3C6EF372FE94F82B_BB67AE8584CAA73B_6A09E667F2BDC948;
    localparam int EXP_LAT32 [3] = '{22, 42, 82};

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_last, out_ready;
    logic [255:0] in_h;
    logic [511:0] in_m;
    logic [63:0]  in_t;
    logic b_in_valid, b_in_last, b_out_ready;
    logic [511:0]  b_in_h;
    logic [1023:0] b_in_m;
    logic [127:0]  b_in_t;

    logic ir_s [4];
    logic ov_s [4];
    logic bz_s [4];
    logic [255:0] oh32 [3];
    logic [511:0] oh64;

    int checks = 0;
    int errors = 0;
    int lat32 [3];
    int lat64;
    logic [255:0] exp_empty32, exp_abc32;
    logic [511:0] exp_abc64;

    always #5 clk = ~clk;

    blake2_compress_seq #(.W(32), .ROUNDS(10), .G_PAR(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s[0]),
        .in_h(in_h), .in_m(in_m), .in_t(in_t), .in_last(in_last),
        .out_valid(ov_s[0]), .out_ready(out_ready), .out_h(oh32[0]), .busy(bz_s[0]));
    blake2_compress_seq #(.W(32), .ROUNDS(10), .G_PAR(2)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s[1]),
        .in_h(in_h), .in_m(in_m), .in_t(in_t), .in_last(in_last),
        .out_valid(ov_s[1]), .out_ready(out_ready), .out_h(oh32[1]), .busy(bz_s[1]));
    blake2_compress_seq #(.W(32), .ROUNDS(10), .G_PAR(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s[2]),
        .in_h(in_h), .in_m(in_m), .in_t(in_t), .in_last(in_last),
        .out_valid(ov_s[2]), .out_ready(out_ready), .out_h(oh32[2]), .busy(bz_s[2]));
    blake2_compress_seq #(.W(64), .ROUNDS(12), .G_PAR(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(ir_s[3]),
        .in_h(b_in_h), .in_m(b_in_m), .in_t(b_in_t), .in_last(b_in_last),
        .out_valid(ov_s[3]), .out_ready(b_out_ready), .out_h(oh64), .busy(bz_s[3]));

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = x[8*(31-k) +: 8];
        return r;
    endfunction

    function automatic logic [511:0] bswap512(input logic [511:0] x);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = x[8*(63-k) +: 8];
        return r;
    endfunction

    // Present one request to the BLAKE2s group, record per-instance latency
    task automatic do_req32(input logic [255:0] h, input logic [511:0] m,
                            input logic [63:0] t, input logic last);
        int cnt;
        in_h = h; in_m = m; in_t = t; in_last = last; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_h = ~h; in_m = ~m; in_t = ~t; in_last = ~last;
        for (int i = 0; i < 3; i++) lat32[i] = -1;
        cnt = 1;
        while (cnt < 200) begin
            for (int i = 0; i < 3; i++) if (ov_s[i] === 1'b1 && lat32[i] < 0) lat32[i] = cnt;
            if (lat32[0] >= 0 && lat32[1] >= 0 && lat32[2] >= 0) break;
            @(posedge clk); #1;
            cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_req64(input logic [511:0] h, input logic [1023:0] m,
                            input logic [127:0] t, input logic last);
        int cnt;
        b_in_h = h; b_in_m = m; b_in_t = t; b_in_last = last; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_h = ~h; b_in_m = ~m; b_in_t = ~t; b_in_last = ~last;
        lat64 = -1;
        cnt = 1;
        while (cnt < 200 && lat64 < 0) begin
            if (ov_s[3] === 1'b1) lat64 = cnt;
            else begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_h = '0; in_m = '0; in_t = '0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
        b_in_h = '0; b_in_m = '0; b_in_t = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov_s[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, ov_s[i]); end
            checks++;
            if (ir_s[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, ir_s[i]); end
            checks++;
            if (bz_s[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bz_s[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oh32[i] !== 256'd0) begin errors++; $display("FAIL reset_out_h[%0d]: got %h want 0", i, oh32[i]); end
        end
        checks++;
        if (oh64 !== 512'd0) begin errors++; $display("FAIL reset_out_h64: got %h want 0", oh64); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty32();
        do_req32(H32, 512'd0, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat32[i] !== EXP_LAT32[i]) begin errors++; $display("FAIL empty_latency[%0d]: got %0d want %0d", i, lat32[i], EXP_LAT32[i]); end
            checks++;
            if (oh32[i] !== exp_empty32) begin errors++; $display("FAIL empty_digest[%0d]: got %h want %h", i, oh32[i], exp_empty32); end
        end
    endtask

    task automatic test_abc32();
        do_req32(H32, 512'h636261, 64'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat32[i] !== EXP_LAT32[i]) begin errors++; $display("FAIL abc_latency[%0d]: got %0d want %0d", i, lat32[i], EXP_LAT32[i]); end
            checks++;
            if (oh32[i] !== exp_abc32) begin errors++; $display("FAIL abc_digest[%0d]: got %h want %h", i, oh32[i], exp_abc32); end
        end
    endtask

    task automatic test_abc64();
        do_req64(H64, 1024'h636261, 128'd3, 1'b1);
        checks++;
        if (lat64 !== 26) begin errors++; $display("FAIL abc64_latency: got %0d want 26", lat64); end
        checks++;
        if (oh64 !== exp_abc64) begin errors++; $display("FAIL abc64_digest: got %h want %h", oh64, exp_abc64); end
    endtask

    task automatic test_backpressure();
        int cnt;
        out_ready = 1'b0;
        in_h = H32; in_m = 512'h636261; in_t = 64'd3; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        // different request held valid while the engine is busy
        in_h = ~H32; in_m = 512'd0; in_t = 64'd0; in_last = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ir_s[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_in_run: got %b want 0", ir_s[0]); end
        checks++;
        if (bz_s[0] !== 1'b1) begin errors++; $display("FAIL bp_busy_in_run: got %b want 1", bz_s[0]); end
        cnt = 0;
        while (ov_s[0] !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ov_s[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", c, ov_s[0]); end
            checks++;
            if (oh32[0] !== exp_abc32) begin errors++; $display("FAIL bp_out_h_hold[%0d]: got %h want %h", c, oh32[0], exp_abc32); end
            checks++;
            if (ir_s[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_in_done[%0d]: got %b want 0", c, ir_s[0]); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (ov_s[0] !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", ov_s[0]); end
        checks++;
        if (ir_s[0] !== 1'b1) begin errors++; $display("FAIL bp_no_accept_at_handshake: in_ready got %b want 1", ir_s[0]); end
        checks++;
        if (oh32[0] !== exp_abc32) begin errors++; $display("FAIL bp_out_h_retained: got %h want %h", oh32[0], exp_abc32); end
        cnt = 0;
        while (!(ir_s[0] === 1'b1 && ir_s[1] === 1'b1 && ir_s[2] === 1'b1) && cnt < 120) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt >= 120) begin errors++; $display("FAIL bp_drain_timeout: got %0d cycles want <120", cnt); end
        do_req32(H32, 512'h636261, 64'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oh32[i] !== exp_abc32) begin errors++; $display("FAIL bp_next_digest[%0d]: got %h want %h", i, oh32[i], exp_abc32); end
        end
    endtask

    task automatic test_reset_mid_done();
        int cnt;
        out_ready = 1'b0;
        in_h = H32; in_m = 512'h636261; in_t = 64'd3; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (ov_s[0] !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (ov_s[0] !== 1'b1) begin errors++; $display("FAIL rd_valid_before: got %b want 1", ov_s[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov_s[0] !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b want 0", ov_s[0]); end
        checks++;
        if (oh32[0] !== 256'd0) begin errors++; $display("FAIL rd_out_h_clear: got %h want 0", oh32[0]); end
        checks++;
        if (ir_s[0] !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", ir_s[0]); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        in_h = H32; in_m = 512'h636261; in_t = 64'd3; in_last = 1'b1; in_valid = 1'b1;
        b_in_h = H64; b_in_m = 1024'h636261; b_in_t = 128'd3; b_in_last = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; b_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (bz_s[0] !== 1'b1) begin errors++; $display("FAIL rr_busy_before: got %b want 1", bz_s[0]); end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov_s[i] !== 1'b0) begin errors++; $display("FAIL rr_out_valid[%0d]: got %b want 0", i, ov_s[i]); end
            checks++;
            if (ir_s[i] !== 1'b1) begin errors++; $display("FAIL rr_in_ready[%0d]: got %b want 1", i, ir_s[i]); end
            checks++;
            if (bz_s[i] !== 1'b0) begin errors++; $display("FAIL rr_busy[%0d]: got %b want 0", i, bz_s[i]); end
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_req32(H32, 512'h636261, 64'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oh32[i] !== exp_abc32) begin errors++; $display("FAIL rr_digest[%0d]: got %h want %h", i, oh32[i], exp_abc32); end
        end
        do_req64(H64, 1024'h636261, 128'd3, 1'b1);
        checks++;
        if (oh64 !== exp_abc64) begin errors++; $display("FAIL rr_digest64: got %h want %h", oh64, exp_abc64); end
    endtask

    initial begin
        exp_empty32 = bswap256(256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9);
        exp_abc32   = bswap256(256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982);
        exp_abc64   = bswap512(512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923);
        test_reset();
        test_empty32();
        test_abc32();
        test_abc64();
        test_backpressure();
        test_reset_mid_done();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
